lfsr_ctrl: RTL and testbench

LFSR_CTRL -- requirements
Module: lfsr_ctrl

---
 rtl/lfsr_ctrl.sv | 154 +++++++++++++++
 tb/tb_lfsr_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_ctrl.sv
// Run/pause/step/clear controller for a downstream LFSR: debounces three raw
// buttons and paces shift-enable pulses through a prescaler.
module lfsr_ctrl #(
    parameter int unsigned PRESCALE  = 50_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       engage_btn,
    input  logic       step_btn,
    input  logic       clear_btn,
    input  logic       once_mode,
    input  logic       max_tick,
    output logic       sh_en,
    output logic       rst_en,
    output logic [1:0] state,
    output logic [7:0] period_cnt
);

    localparam int unsigned PS_W     = 32;
    localparam int unsigned DB_W     = 24;
    localparam int unsigned N_BTN    = 3;
    localparam int unsigned BTN_ENG  = 0;
    localparam int unsigned BTN_STEP = 1;
    localparam int unsigned BTN_CLR  = 2;

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DB_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        CLR  = 2'd3
    } state_e;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] fired_q;
    logic [N_BTN-1:0] press_q;
    logic [DB_W-1:0]  db_cnt_q [N_BTN];

    state_e          state_q, state_d;
    logic            sh_en_q, sh_en_d;
    logic            rst_en_q, rst_en_d;
    logic [7:0]      period_q, period_d;
    logic [PS_W-1:0] presc_q, presc_d;

    assign btn_raw = {clear_btn, step_btn, engage_btn};

    // Synchronize, debounce, and emit one press pulse per qualified hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fired_q <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < N_BTN; i++) begin
                if (!sync2_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] != DB_MAX) begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
                // fired_q blocks repeat pulses while the counter sits saturated
                press_q[i] <= (db_cnt_q[i] == DB_MAX) && !fired_q[i];
                fired_q[i] <= sync2_q[i] && (fired_q[i] || (db_cnt_q[i] == DB_MAX));
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLR;
            sh_en_q  <= 1'b0;
            rst_en_q <= 1'b1;
            period_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            sh_en_q  <= sh_en_d;
            rst_en_q <= rst_en_d;
            period_q <= period_d;
            presc_q  <= presc_d;
        end
    end

    // Next-state and registered-output logic; clear outranks engage outranks step.
    always_comb begin
        state_d  = state_q;
        sh_en_d  = 1'b0;
        period_d = period_q;
        presc_d  = presc_q;
        rst_en_d = 1'b0;

        if (press_q[BTN_CLR]) begin
            state_d  = CLR;
            period_d = '0;
            presc_d  = '0;
        end else begin
            case (state_q)
                CLR: begin
                    state_d  = IDLE;
                    period_d = '0;
                    presc_d  = '0;
                end
                IDLE: begin
                    if (press_q[BTN_ENG]) begin
                        state_d = RUN;
                        presc_d = '0;
                    end else if (press_q[BTN_STEP]) begin
                        sh_en_d = 1'b1;
                    end
                end
                RUN: begin
                    if (max_tick) begin
                        period_d = period_q + 8'd1;
                    end
                    if (press_q[BTN_ENG]) begin
                        state_d = IDLE;
                    end else if (max_tick && once_mode) begin
                        state_d = DONE;
                    end else if (presc_q == PS_LAST) begin
                        presc_d = '0;
                        sh_en_d = 1'b1;
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = CLR;
                end
            endcase
        end

        rst_en_d = (state_d == CLR);
    end

    assign sh_en      = sh_en_q;
    assign rst_en     = rst_en_q;
    assign state      = state_q;
    assign period_cnt = period_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with a behavioural reference model checked
// every cycle, plus literal expectations at the key points.
module tb_lfsr_ctrl;

    localparam int P  = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       engage_btn, step_btn, clear_btn, once_mode, max_tick;
    logic       sh_en, rst_en;
    logic [1:0] state;
    logic [7:0] period_cnt;

    int checks   = 0;
    int failures = 0;
    int sh_total = 0;
    int rst_total = 0;
    int sh0, rst0;

    // reference model state
    int m_state, m_sh, m_rst, m_per, m_age;
    int run_len [3];
    bit [3:0] dly [3];

    lfsr_ctrl #(.PRESCALE(P), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .engage_btn (engage_btn),
        .step_btn   (step_btn),
        .clear_btn  (clear_btn),
        .once_mode  (once_mode),
        .max_tick   (max_tick),
        .sh_en      (sh_en),
        .rst_en     (rst_en),
        .state      (state),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A press is recognised when the raw run of highs reaches exactly DB
    // samples; two sync flops, the counter and the pulse register put the
    // FSM reaction four edges after that sample.
    task automatic model_step();
        bit pr [3];
        bit b  [3];
        b[0] = engage_btn; b[1] = step_btn; b[2] = clear_btn;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                run_len[i] = 0;
                dly[i] = '0;
            end
            m_state = 3; m_sh = 0; m_rst = 1; m_per = 0; m_age = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pr[i] = dly[i][3];
                run_len[i] = b[i] ? ((run_len[i] <= DB) ? run_len[i] + 1 : run_len[i]) : 0;
                dly[i] = {dly[i][2:0], (run_len[i] == DB)};
            end
            m_sh = 0;
            if (pr[2]) begin
                m_state = 3;
                m_per = 0;
            end else if (m_state == 3) begin
                m_state = 0;
            end else if (m_state == 0) begin
                if (pr[0]) begin
                    m_state = 1;
                    m_age = 0;
                end else if (pr[1]) begin
                    m_sh = 1;
                end
            end else if (m_state == 1) begin
                if (max_tick) m_per = (m_per + 1) % 256;
                if (pr[0]) m_state = 0;
                else if (max_tick && once_mode) m_state = 2;
                else begin
                    m_age++;
                    if (m_age % P == 0) m_sh = 1;
                end
            end
            m_rst = (m_state == 3) ? 1 : 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_state", int'(state), m_state);
        check("model_sh_en", int'(sh_en), m_sh);
        check("model_rst_en", int'(rst_en), m_rst);
        check("model_period", int'(period_cnt), m_per);
        sh_total += int'(sh_en);
        rst_total += int'(rst_en);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: engage_btn = v;
            1: step_btn = v;
            default: clear_btn = v;
        endcase
    endtask

    // hold a button for 5 samples, then let the press act and settle
    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (5) cycle();
        set_btn(which, 1'b0);
        repeat (6) cycle();
    endtask

    initial begin
        logic [10:0] bounce;
        rst_n = 1'b0; engage_btn = 0; step_btn = 0; clear_btn = 0;
        once_mode = 0; max_tick = 0;
        m_state = 3; m_sh = 0; m_rst = 1; m_per = 0; m_age = 0;
        for (int i = 0; i < 3; i++) begin
            run_len[i] = 0;
            dly[i] = '0;
        end
        #2;

        repeat (3) cycle();
        check("rst_state", int'(state), 3);
        check("rst_rst_en", int'(rst_en), 1);
        check("rst_sh_en", int'(sh_en), 0);
        check("rst_period", int'(period_cnt), 0);

        rst_n = 1'b1;
        cycle();
        check("clr_exit_state", int'(state), 0);
        check("clr_exit_rst_en", int'(rst_en), 0);

        // engage held from edge 0: RUN at edge 6, first sh_en 4 cycles later
        engage_btn = 1'b1;
        repeat (6) cycle();
        check("eng_edge5_state", int'(state), 0);
        cycle();
        check("eng_edge6_state", int'(state), 1);
        engage_btn = 1'b0;
        repeat (3) cycle();
        check("first_sh_early", int'(sh_en), 0);
        cycle();
        check("first_sh", int'(sh_en), 1);
        sh0 = sh_total;
        repeat (16) cycle();
        check("sh_rate", sh_total - sh0, 4);

        // pause, then single step
        press(0);
        check("pause_state", int'(state), 0);
        sh0 = sh_total;
        repeat (12) cycle();
        check("pause_no_sh", sh_total - sh0, 0);
        sh0 = sh_total;
        press(1);
        check("step_one_sh", sh_total - sh0, 1);
        check("step_state", int'(state), 0);

        // once mode: one max_tick ends the run
        once_mode = 1'b1;
        press(0);
        check("once_run", int'(state), 1);
        max_tick = 1'b1;
        cycle();
        max_tick = 1'b0;
        check("once_period", int'(period_cnt), 1);
        check("once_done", int'(state), 2);
        check("once_sh", int'(sh_en), 0);
        sh0 = sh_total;
        press(0);
        press(1);
        max_tick = 1'b1;
        cycle();
        max_tick = 1'b0;
        cycle();
        check("done_hold_state", int'(state), 2);
        check("done_no_sh", sh_total - sh0, 0);
        check("done_tick_ignored", int'(period_cnt), 1);
        rst0 = rst_total;
        press(2);
        check("clear_rst_pulse", rst_total - rst0, 1);
        check("clear_state", int'(state), 0);
        check("clear_period", int'(period_cnt), 0);

        // 256 periods with once_mode low wrap the counter
        once_mode = 1'b0;
        press(0);
        for (int k = 0; k < 255; k++) begin
            max_tick = 1'b1;
            cycle();
            max_tick = 1'b0;
            cycle();
        end
        check("period_255", int'(period_cnt), 255);
        max_tick = 1'b1;
        cycle();
        max_tick = 1'b0;
        cycle();
        check("period_wrap", int'(period_cnt), 0);
        check("wrap_state", int'(state), 1);

        // coincident clear and engage in RUN: clear wins
        engage_btn = 1'b1; clear_btn = 1'b1;
        repeat (5) cycle();
        engage_btn = 1'b0; clear_btn = 1'b0;
        cycle();
        cycle();
        check("coinc_clr", int'(state), 3);
        check("coinc_rst_en", int'(rst_en), 1);
        cycle();
        check("coinc_idle", int'(state), 0);

        // bouncing step never qualifies
        bounce = 11'b01101001011;
        sh0 = sh_total;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 11; k++) begin
                step_btn = bounce[k];
                cycle();
            end
        end
        step_btn = 1'b0;
        repeat (8) cycle();
        check("bounce_no_sh", sh_total - sh0, 0);

        // reset mid-RUN with a step press half debounced
        press(0);
        repeat (2) cycle();
        step_btn = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        check("midrst_state", int'(state), 3);
        check("midrst_rst_en", int'(rst_en), 1);
        check("midrst_sh_en", int'(sh_en), 0);
        step_btn = 1'b0;
        rst_n = 1'b1;
        cycle();
        check("midrst_idle", int'(state), 0);
        sh0 = sh_total;
        repeat (10) cycle();
        check("midrst_no_sh", sh_total - sh0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
